// File: rtl/vector_alu.sv
// Sequential vector ALU: walks element k = 0..N-1, reads both operands combinationally and writes one result per cycle.
// Optional macro VECTOR_ALU_SAT_EN: signed saturation of ADD/SUB with a sticky overflow flag.
module vector_alu #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 8,
    localparam int AW = $clog2(MEM_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [2:0]           op_i,
    input  logic [LW-1:0]        len_i,
    input  logic [MEM_WIDTH-1:0] operand1_i,
    input  logic [MEM_WIDTH-1:0] operand2_i,
    output logic [AW-1:0]        operand1_addr_o,
    output logic [AW-1:0]        operand2_addr_o,
    output logic [MEM_WIDTH-1:0] result_o,
    output logic [AW-1:0]        result_addr_o,
    output logic                 result_we_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_MIN = 3'd6;
    localparam logic [2:0] OP_MAX = 3'd7;

    localparam logic [MEM_WIDTH-1:0] MOST_POS = {1'b0, {(MEM_WIDTH-1){1'b1}}};
    localparam logic [MEM_WIDTH-1:0] MOST_NEG = {1'b1, {(MEM_WIDTH-1){1'b0}}};

    state_e               state_q;
    logic [2:0]           op_q;
    logic [LW-1:0]        len_q;
    logic [AW-1:0]        k_q;
    logic [MEM_WIDTH-1:0] result_q;
    logic [AW-1:0]        result_addr_q;
    logic                 we_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 ovf_q;

    logic signed [MEM_WIDTH-1:0] opa;
    logic signed [MEM_WIDTH-1:0] opb;
    logic [MEM_WIDTH-1:0]        res_d;
    logic                        sat_d;
    logic [MEM_WIDTH:0]          addsub_d;
    logic [LW-1:0]               len_eff;
    logic                        last_elem;

    // Returns {saturated, result}; the wide sum exposes signed overflow as a
    // disagreement between its top two bits.
    function automatic logic [MEM_WIDTH:0] sat_addsub(
        input logic signed [MEM_WIDTH-1:0] a,
        input logic signed [MEM_WIDTH-1:0] b,
        input logic                        sub
    );
        logic signed [MEM_WIDTH:0] wide;
        wide = sub ? ({a[MEM_WIDTH-1], a} - {b[MEM_WIDTH-1], b})
                   : ({a[MEM_WIDTH-1], a} + {b[MEM_WIDTH-1], b});
`ifdef VECTOR_ALU_SAT_EN
        if (wide[MEM_WIDTH] != wide[MEM_WIDTH-1]) begin
            return {1'b1, (wide[MEM_WIDTH] ? MOST_NEG : MOST_POS)};
        end
`endif
        return {1'b0, wide[MEM_WIDTH-1:0]};
    endfunction

    assign opa       = operand1_i;
    assign opb       = operand2_i;
    assign len_eff   = (len_i > LW'(MEM_DEPTH)) ? LW'(MEM_DEPTH) : len_i;
    assign last_elem = ({1'b0, k_q} == (len_q - LW'(1)));

    always_comb begin
        res_d    = '0;
        sat_d    = 1'b0;
        addsub_d = '0;
        case (op_q)
            OP_ADD: begin
                addsub_d = sat_addsub(opa, opb, 1'b0);
                res_d    = addsub_d[MEM_WIDTH-1:0];
                sat_d    = addsub_d[MEM_WIDTH];
            end
            OP_SUB: begin
                addsub_d = sat_addsub(opa, opb, 1'b1);
                res_d    = addsub_d[MEM_WIDTH-1:0];
                sat_d    = addsub_d[MEM_WIDTH];
            end
            OP_AND:  res_d = operand1_i & operand2_i;
            OP_OR:   res_d = operand1_i | operand2_i;
            OP_XOR:  res_d = operand1_i ^ operand2_i;
            OP_MUL:  res_d = operand1_i * operand2_i;
            OP_MIN:  res_d = (opa < opb) ? operand1_i : operand2_i;
            OP_MAX:  res_d = (opa > opb) ? operand1_i : operand2_i;
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            op_q          <= '0;
            len_q         <= '0;
            k_q           <= '0;
            result_q      <= '0;
            result_addr_q <= '0;
            we_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        op_q  <= op_i;
                        len_q <= len_eff;
                        k_q   <= '0;
                        ovf_q <= 1'b0;
                        if (len_eff == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    result_q      <= res_d;
                    result_addr_q <= k_q;
                    we_q          <= 1'b1;
                    k_q           <= k_q + AW'(1);
                    if (sat_d) begin
                        ovf_q <= 1'b1;
                    end
                    // The final capture and the completion pulse land in the same cycle.
                    if (last_elem) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign operand1_addr_o = (state_q == RUN) ? k_q : '0;
    assign operand2_addr_o = (state_q == RUN) ? k_q : '0;
    assign result_o        = result_q;
    assign result_addr_o   = result_addr_q;
    assign result_we_o     = we_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign overflow_o      = ovf_q;

endmodule

// File: tb/tb_vector_alu.sv
// Randomized bench for vector_alu against a plain-arithmetic reference model.
module tb_vector_alu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [2:0]  op_i;
    logic [3:0]  len_i;
    logic [31:0] operand1_i, operand2_i;
    logic [2:0]  operand1_addr_o, operand2_addr_o;
    logic [31:0] result_o;
    logic [2:0]  result_addr_o;
    logic        result_we_o, busy_o, done_o, overflow_o;

    logic [31:0] m1 [8];
    logic [31:0] m2 [8];
    logic [31:0] res_seen [8];
    int total = 0;
    int bad = 0;

    vector_alu #(.MEM_WIDTH(32), .MEM_DEPTH(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i), .len_i(len_i),
        .operand1_i(operand1_i), .operand2_i(operand2_i),
        .operand1_addr_o(operand1_addr_o), .operand2_addr_o(operand2_addr_o),
        .result_o(result_o), .result_addr_o(result_addr_o), .result_we_o(result_we_o),
        .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    assign operand1_i = m1[operand1_addr_o];
    assign operand2_i = m2[operand2_addr_o];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input int op, input logic [31:0] a,
                                           input logic [31:0] b, output bit sat);
        longint sa, sb, s;
        longint unsigned p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sat = 1'b0;
        case (op)
            0, 1: begin
                s = (op == 0) ? sa + sb : sa - sb;
`ifdef VECTOR_ALU_SAT_EN
                if (s > 64'sd2147483647) begin sat = 1'b1; return 32'h7FFFFFFF; end
                if (s < -64'sd2147483648) begin sat = 1'b1; return 32'h80000000; end
`endif
                return s[31:0];
            end
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: begin p = longint'(a) * longint'(b); return p[31:0]; end
            6: return (sa < sb) ? a : b;
            default: return (sa > sb) ? a : b;
        endcase
    endfunction

    task automatic run_op(input int op, input int len, input bit inject);
        int n, writes, done_c;
        bit done_we, any_sat, s;
        logic [31:0] e;
        n = (len > 8) ? 8 : len;
        writes = 0; done_c = -1; done_we = 1'b0; any_sat = 1'b0;
        @(negedge clk_i);
        start_i = 1'b1; op_i = 3'(op); len_i = 4'(len);
        @(negedge clk_i);
        start_i = 1'b0; op_i = 3'($urandom); len_i = 4'($urandom);
        check("busy_c0", busy_o, (n > 0));
        check("ovf_clr", overflow_o, 0);
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) @(negedge clk_i);
            if (result_we_o) begin
                check("waddr", result_addr_o, writes);
                if (writes < 8) res_seen[writes] = result_o;
                writes++;
            end
            if (done_o) begin
                done_c = c;
                done_we = result_we_o;
                break;
            end
            if (inject) begin
                start_i = (c == 3);
                op_i = 3'd4;
                len_i = 4'd8;
            end
        end
        start_i = 1'b0;
        check("done_cyc", done_c, (n == 0) ? 0 : n);
        check("n_writes", writes, n);
        check("done_we", done_we, (n > 0));
        for (int i = 0; i < n; i++) begin
            e = ref_op(op, m1[i], m2[i], s);
            any_sat |= s;
            check($sformatf("res[%0d] op%0d", i, op), res_seen[i], e);
        end
        check("ovf", overflow_o, any_sat);
        @(negedge clk_i);
        check("done_low", done_o, 0);
        check("busy_low", busy_o, 0);
        check("we_low", result_we_o, 0);
        if (n > 0) check("hold", {result_addr_o, result_o}, {3'(n - 1), res_seen[n-1]});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_res"}, result_o, 0);
        check({tag, "_raddr"}, result_addr_o, 0);
        check({tag, "_addr"}, {operand1_addr_o, operand2_addr_o}, 0);
        check({tag, "_ctl"}, {result_we_o, busy_o, done_o, overflow_o}, 0);
    endtask

    initial begin
        int wcnt;
        logic [31:0] ext [4];
        ext[0] = 32'h7FFFFFFF; ext[1] = 32'h80000000; ext[2] = 32'hFFFFFFFF; ext[3] = 32'h1;
        rst_ni = 1'b0; start_i = 1'b0; op_i = '0; len_i = '0;
        for (int i = 0; i < 8; i++) begin m1[i] = '0; m2[i] = '0; res_seen[i] = '0; end
        repeat (2) @(posedge clk_i);
        #2;
        check_zero("rst");
        rst_ni = 1'b1;

        // ADD over the full vector
        for (int i = 0; i < 8; i++) begin m1[i] = i + 1; m2[i] = 10 * (i + 1); end
        run_op(0, 8, 1'b0);
        check("add_first", res_seen[0], 11);
        check("add_last", res_seen[7], 88);

        // SUB / MIN / MAX on a single element
        m1[0] = 3; m2[0] = 5;
        run_op(1, 1, 1'b0);
        check("sub_wrap", res_seen[0], 32'hFFFFFFFE);
        run_op(6, 1, 1'b0);
        check("min", res_seen[0], 3);
        run_op(7, 1, 1'b0);
        check("max", res_seen[0], 5);

        // Zero length and length clamping
        run_op(3, 0, 1'b0);
        run_op(0, 15, 1'b0);

        // start_i with XOR during an ADD run is ignored
        run_op(0, 8, 1'b1);

        // Signed overflow boundary
        m1[0] = 32'h7FFFFFFF; m2[0] = 32'h1;
        run_op(0, 1, 1'b0);
`ifdef VECTOR_ALU_SAT_EN
        check("sat_res", res_seen[0], 32'h7FFFFFFF);
`else
        check("wrap_res", res_seen[0], 32'h80000000);
`endif
        run_op(2, 1, 1'b0);

        // Reset in the middle of a run
        for (int i = 0; i < 8; i++) begin m1[i] = $urandom; m2[i] = $urandom; end
        @(negedge clk_i);
        start_i = 1'b1; op_i = 3'd0; len_i = 4'd8;
        @(negedge clk_i);
        start_i = 1'b0;
        wcnt = 0;
        for (int c = 0; c < 12 && wcnt < 3; c++) begin
            @(negedge clk_i);
            if (result_we_o) wcnt++;
        end
        check("pre_abort_writes", wcnt, 3);
        #2 rst_ni = 1'b0;
        #1 check_zero("abort");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("abort_hold", {result_we_o, busy_o}, 0);
        end
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        // Start offered right after release must be taken on the first edge.
        run_op(5, 8, 1'b0);

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 8; i++) begin
                m1[i] = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 3)] : $urandom;
                m2[i] = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 3)] : $urandom;
            end
            run_op($urandom_range(0, 7), $urandom_range(0, 15), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
